// File: rtl/timer_pkg.sv
// Shared definitions for the timer datapath count registers.
package timer_pkg;

  // Operation select width and encodings.
  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD    = 3'd0;
  localparam logic [MODE_W-1:0] MODE_LOAD    = 3'd1;
  localparam logic [MODE_W-1:0] MODE_UP      = 3'd2;
  localparam logic [MODE_W-1:0] MODE_DOWN    = 3'd3;
  localparam logic [MODE_W-1:0] MODE_TOGGLE  = 3'd4;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 3'd5;

  // Enumerated view of the mode field; codes 6 and 7 are reserved and hold.
  typedef enum logic [MODE_W-1:0] {
    OP_HOLD    = 3'd0,
    OP_LOAD    = 3'd1,
    OP_UP      = 3'd2,
    OP_DOWN    = 3'd3,
    OP_TOGGLE  = 3'd4,
    OP_ONESHOT = 3'd5,
    OP_RSVD6   = 3'd6,
    OP_RSVD7   = 3'd7
  } op_e;

  // Decode a raw mode field into the enumerated operation.
  function automatic op_e decode_mode(input logic [MODE_W-1:0] mode);
    return op_e'(mode);
  endfunction

endpackage

// File: rtl/timer_count_next.sv
// Combinational next-value logic for the multi-mode count register.
// wrap flags a modulus wrap in UP/DOWN; hit_zero flags that a ONESHOT step
// lands on (or sits at) zero and should raise the sticky done flag.
module timer_count_next
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MODULUS = 60
) (
  input  logic [WIDTH-1:0]  q,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  tgl_mask,
  output logic [WIDTH-1:0]  next_q,
  output logic              wrap,
  output logic              hit_zero
);

  // Largest legal count value; MODULUS == 2^WIDTH gives all-ones.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  // Modulus widened by one bit so 2^WIDTH is representable for the clamp test.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  op_e op;
  logic q_is_zero;
  logic q_at_top;
  logic load_over;

  assign op        = decode_mode(mode);
  assign q_is_zero = (q == ZERO);
  // ">=" so values pushed out of range by TOGGLE still wrap on the next UP.
  assign q_at_top  = (q >= MAX_VAL);
  assign load_over = ({1'b0, load_val} >= MOD_EXT);

  // Select the next value and the wrap / zero-hit qualifiers for each op.
  always_comb begin
    next_q   = q;
    wrap     = 1'b0;
    hit_zero = 1'b0;
    unique case (op)
      OP_LOAD: begin
        next_q = load_over ? MAX_VAL : load_val;
      end
      OP_UP: begin
        if (q_at_top) begin
          next_q = ZERO;
          wrap   = 1'b1;
        end else begin
          next_q = q + ONE;
        end
      end
      OP_DOWN: begin
        if (q_is_zero) begin
          next_q = MAX_VAL;
          wrap   = 1'b1;
        end else begin
          next_q = q - ONE;
        end
      end
      OP_TOGGLE: begin
        next_q = q ^ tgl_mask;
      end
      OP_ONESHOT: begin
        if (q_is_zero) begin
          next_q   = ZERO;
          hit_zero = 1'b1;
        end else begin
          next_q   = q - ONE;
          hit_zero = (q == ONE);
        end
      end
      OP_HOLD, OP_RSVD6, OP_RSVD7: begin
        next_q = q;
      end
      default: begin
        next_q = q;
      end
    endcase
  end

endmodule

// File: rtl/timer_count_reg.sv
// Multi-mode count register: hold / load / up / down / toggle / one-shot,
// with a registered wrap pulse for cascading and a sticky done flag.
module timer_count_reg
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MODULUS   = 60,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  load_val,
  input  logic [WIDTH-1:0]  tgl_mask,
  output logic [WIDTH-1:0]  q,
  output logic              carry,
  output logic              done
);

  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] next_q;
  logic             wrap;
  logic             hit_zero;

  timer_count_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .q        (q_q),
    .mode     (mode),
    .load_val (load_val),
    .tgl_mask (tgl_mask),
    .next_q   (next_q),
    .wrap     (wrap),
    .hit_zero (hit_zero)
  );

  // Gate the next-state by en; done is set by a zero hit and cleared only by LOAD.
  always_comb begin
    q_d     = q_q;
    carry_d = 1'b0;
    done_d  = done_q;
    if (en) begin
      q_d     = next_q;
      carry_d = wrap;
      if (mode == MODE_LOAD) begin
        done_d = 1'b0;
      end else if (hit_zero) begin
        done_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset taking priority over en.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q     <= RST_Q;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      carry_q <= carry_d;
      done_q  <= done_d;
    end
  end

  assign q     = q_q;
  assign carry = carry_q;
  assign done  = done_q;

endmodule
